// File: rtl/snake_logic.sv
// Snake game datapath: moves, collides, grows and re-seeds food once per controller tick.
// Latency: LOGIC_DONE 3 cycles after a sampled tick edge for a plain move, longer when food is re-fetched.
// Backpressure: ticks arriving outside IDLE are dropped; the PRNG fetch stalls on rng_ack indefinitely.
module snake_logic #(
  parameter int         MAX_LEN   = 16,
  parameter int         INIT_LEN  = 3,
  parameter logic [5:0] FOOD_INIT = 6'd45
) (
  input  logic            clka,
  input  logic            restart,
  input  logic [1:0]      to_logic,
  input  logic [1:0]      direction_state,
  output logic [1:0]      from_logic,
  output logic [7:0][7:0] led_array,
  output logic            rng_req,
  input  logic            rng_ack,
  input  logic [5:0]      rng_data,
  output logic [5:0]      snake_len
);

  localparam int PW = $clog2(MAX_LEN);
  // Initial snake lies on row 3 starting at column 0 (cell 24 upward).
  localparam logic [63:0] INIT_GRID = ((64'd1 << INIT_LEN) - 64'd1) << 24;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_COMMIT, S_RNG_REQ, S_RNG_WAIT, S_SCAN
  } state_t;

  state_t          r_state;
  logic [5:0]      r_body [MAX_LEN];
  logic [PW-1:0]   r_head_ptr;
  logic [PW-1:0]   r_tail_ptr;
  logic [63:0]     r_grid;
  logic [5:0]      r_food;
  logic [5:0]      r_len;
  logic            r_blink;
  logic            r_done;
  logic            r_game_end;
  logic            r_rng_req;
  logic            r_tick_prev;
  logic            r_tick_edge;
  logic [5:0]      r_next;
  logic            r_eat;
  logic            r_grow;
  logic            r_hit;
  logic [5:0]      r_cand;

  logic [5:0]      w_head;
  logic [5:0]      w_tail;
  logic [5:0]      w_next;
  logic            w_grow;
  logic [PW-1:0]   w_head_ptr_inc;
  logic [PW-1:0]   w_tail_ptr_inc;
  logic [63:0]     w_image;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_head         = r_body[r_head_ptr];
  assign w_tail         = r_body[r_tail_ptr];
  assign w_head_ptr_inc = ptr_inc(r_head_ptr);
  assign w_tail_ptr_inc = ptr_inc(r_tail_ptr);
  assign w_grow         = (w_next == r_food) && (r_len < 6'(MAX_LEN));

  assign from_logic = {r_game_end, r_done};
  assign rng_req    = r_rng_req;
  assign snake_len  = r_len;
  assign led_array  = w_image;

  // Candidate head: one step in the requested direction, each axis wraps on 3 bits.
  always_comb begin
    w_next = w_head;
    case (direction_state)
      2'd0:    w_next = {3'(w_head[5:3] + 3'd1), w_head[2:0]};
      2'd1:    w_next = {3'(w_head[5:3] - 3'd1), w_head[2:0]};
      2'd2:    w_next = {w_head[5:3], 3'(w_head[2:0] - 3'd1)};
      default: w_next = {w_head[5:3], 3'(w_head[2:0] + 3'd1)};
    endcase
  end

  // Display image; after game over the head pixel blinks with each paused tick.
  always_comb begin
    w_image = r_grid | (64'd1 << r_food);
    if (r_game_end) w_image[w_head] = ~r_blink;
  end

  // Rising-edge detector on LOGIC_TICK; prev resets high so a held tick is not seen as new.
  always_ff @(posedge clka) begin
    if (restart) begin
      r_tick_prev <= 1'b1;
      r_tick_edge <= 1'b0;
    end else begin
      r_tick_prev <= to_logic[0];
      r_tick_edge <= to_logic[0] & ~r_tick_prev;
    end
  end

  // Game FSM: tick accept, move evaluation, body/grid commit, food fetch and free-cell scan.
  always_ff @(posedge clka) begin
    if (restart) begin
      r_state <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_body[i] <= (i < INIT_LEN) ? 6'(24 + i) : 6'd0;
      end
      r_head_ptr <= PW'(INIT_LEN - 1);
      r_tail_ptr <= '0;
      r_grid     <= INIT_GRID;
      r_food     <= FOOD_INIT;
      r_len      <= 6'(INIT_LEN);
      r_blink    <= 1'b0;
      r_done     <= 1'b0;
      r_game_end <= 1'b0;
      r_rng_req  <= 1'b0;
      r_next     <= 6'd0;
      r_eat      <= 1'b0;
      r_grow     <= 1'b0;
      r_hit      <= 1'b0;
      r_cand     <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_tick_edge) begin
            if (to_logic[1] || r_game_end) begin
              r_blink <= ~r_blink;
              r_done  <= 1'b1;
            end else begin
              r_done  <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_next  <= w_next;
          r_eat   <= (w_next == r_food);
          r_grow  <= w_grow;
          // Moving into the tail cell is legal when that tail is vacating this tick.
          r_hit   <= r_grid[w_next] && !((w_next == w_tail) && !w_grow);
          r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          if (r_hit) begin
            r_game_end <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            // Tail clear precedes head set so a head entering the old tail cell stays lit.
            if (!r_grow) begin
              r_grid[w_tail] <= 1'b0;
              r_tail_ptr     <= w_tail_ptr_inc;
            end
            r_grid[r_next]         <= 1'b1;
            r_body[w_head_ptr_inc] <= r_next;
            r_head_ptr             <= w_head_ptr_inc;
            if (r_grow) r_len <= r_len + 6'd1;
            if (r_eat) begin
              r_rng_req <= 1'b1;
              r_state   <= S_RNG_REQ;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_RNG_REQ, S_RNG_WAIT: begin
          if (rng_ack) begin
            r_cand    <= rng_data;
            r_rng_req <= 1'b0;
            r_state   <= S_SCAN;
          end else begin
            r_state <= S_RNG_WAIT;
          end
        end
        S_SCAN: begin
          if (!r_grid[r_cand]) begin
            r_food  <= r_cand;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cand <= r_cand + 6'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_logic.sv
// Directed bench for snake_logic: reset image, tick latency, wrap, eat/scan, collision/blink, abort.
// Samples outputs on the falling edge; drives inputs from one initial block.
// The PRNG side answers only when the bench chooses to, so stalls are exercised explicitly.
module tb_snake_logic;

  logic            clka = 1'b0;
  logic            restart;
  logic [1:0]      to_logic;
  logic [1:0]      direction_state;
  logic [1:0]      from_logic;
  logic [7:0][7:0] led_array;
  logic            rng_req;
  logic            rng_ack;
  logic [5:0]      rng_data;
  logic [5:0]      snake_len;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

  snake_logic dut (
    .clka            (clka),
    .restart         (restart),
    .to_logic        (to_logic),
    .direction_state (direction_state),
    .from_logic      (from_logic),
    .led_array       (led_array),
    .rng_req         (rng_req),
    .rng_ack         (rng_ack),
    .rng_data        (rng_data),
    .snake_len       (snake_len)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clka);
    restart  = 1'b1;
    to_logic = 2'b00;
    rng_ack  = 1'b0;
    rng_data = 6'd0;
    repeat (2) @(negedge clka);
    restart = 1'b0;
    repeat (2) @(negedge clka);
  endtask

  // Pulse LOGIC_TICK for one cycle with NO_UPDATE held, then let the move settle.
  task automatic do_tick(input logic [1:0] dir, input logic nu);
    direction_state = dir;
    to_logic = {nu, 1'b1};
    @(negedge clka);
    to_logic = {nu, 1'b0};
    repeat (5) @(negedge clka);
    to_logic = 2'b00;
  endtask

  // Tick with the DONE timing checked on each falling edge after the sampling edge.
  task automatic latency_tick(input string tag, input logic [1:0] dir);
    direction_state = dir;
    to_logic = 2'b01;
    @(negedge clka);
    to_logic = 2'b00;
    @(negedge clka);
    chk({tag, "_done_cleared"}, 64'(from_logic[0]), 64'd0);
    @(negedge clka);
    chk({tag, "_done_2cyc"}, 64'(from_logic[0]), 64'd0);
    @(negedge clka);
    chk({tag, "_done_3cyc"}, 64'(from_logic[0]), 64'd1);
    @(negedge clka);
  endtask

  initial begin
    restart = 1'b0;
    to_logic = 2'b00;
    direction_state = RIGHT;
    rng_ack = 1'b0;
    rng_data = 6'd0;

    // Reset image: snake row 3 cols 0..2, food at (5,5).
    do_reset();
    chk("rst_row3", 64'(led_array[3]), 64'h07);
    chk("rst_row5", 64'(led_array[5]), 64'h20);
    chk("rst_row0", 64'(led_array[0]), 64'h00);
    chk("rst_from", 64'(from_logic), 64'd0);
    chk("rst_len", 64'(snake_len), 64'd3);
    chk("rst_rngreq", 64'(rng_req), 64'd0);

    // One step right, exact latency, then DONE clears on the next accepted tick.
    latency_tick("t2a", RIGHT);
    chk("t2_row3", 64'(led_array[3]), 64'h0E);
    chk("t2_from", 64'(from_logic), 64'd1);
    latency_tick("t2b", RIGHT);
    chk("t2b_row3", 64'(led_array[3]), 64'h1C);

    // Continue right until head reaches col 7, then wrap to col 0.
    do_tick(RIGHT, 1'b0);
    do_tick(RIGHT, 1'b0);
    do_tick(RIGHT, 1'b0);
    chk("t3_col7_row3", 64'(led_array[3]), 64'hE0);
    do_tick(RIGHT, 1'b0);
    chk("t3_wrap_row3", 64'(led_array[3]), 64'hC1);
    chk("t3_no_end", 64'(from_logic), 64'd1);
    chk("t3_len", 64'(snake_len), 64'd3);

    // Eat at 45, PRNG offers 43; 43..45 are body so food lands on 46.
    do_reset();
    do_tick(UP, 1'b0);
    do_tick(UP, 1'b0);
    chk("t4_row4", 64'(led_array[4]), 64'h04);
    chk("t4_row5_pre", 64'(led_array[5]), 64'h24);
    do_tick(RIGHT, 1'b0);
    do_tick(RIGHT, 1'b0);
    do_tick(RIGHT, 1'b0);
    chk("t4_rngreq", 64'(rng_req), 64'd1);
    chk("t4_done_wait", 64'(from_logic[0]), 64'd0);
    rng_ack = 1'b1;
    rng_data = 6'd43;
    @(negedge clka);
    rng_ack = 1'b0;
    chk("t4_rngreq_drop", 64'(rng_req), 64'd0);
    for (int i = 0; i < 80 && !from_logic[0]; i++) @(negedge clka);
    chk("t4_scan_done", 64'(from_logic[0]), 64'd1);
    chk("t4_row5", 64'(led_array[5]), 64'h7C);
    chk("t4_row4_post", 64'(led_array[4]), 64'h00);
    chk("t4_len", 64'(snake_len), 64'd4);

    // Reversal into neck collides; paused ticks blink the head only.
    do_reset();
    do_tick(LEFT, 1'b0);
    chk("t5_end", 64'(from_logic), 64'd3);
    chk("t5_row3", 64'(led_array[3]), 64'h07);
    do_tick(LEFT, 1'b1);
    chk("t5_blink_off", 64'(led_array[3]), 64'h03);
    chk("t5_row5_off", 64'(led_array[5]), 64'h20);
    do_tick(LEFT, 1'b1);
    chk("t5_blink_on", 64'(led_array[3]), 64'h07);
    chk("t5_from", 64'(from_logic), 64'd3);
    chk("t5_len", 64'(snake_len), 64'd3);

    // Restart while waiting on the PRNG aborts the fetch.
    do_reset();
    do_tick(UP, 1'b0);
    do_tick(UP, 1'b0);
    do_tick(RIGHT, 1'b0);
    do_tick(RIGHT, 1'b0);
    do_tick(RIGHT, 1'b0);
    chk("t6_rngreq", 64'(rng_req), 64'd1);
    repeat (3) @(negedge clka);
    restart = 1'b1;
    @(negedge clka);
    restart = 1'b0;
    chk("t6_rngreq_abort", 64'(rng_req), 64'd0);
    chk("t6_row3", 64'(led_array[3]), 64'h07);
    chk("t6_row5", 64'(led_array[5]), 64'h20);
    chk("t6_len", 64'(snake_len), 64'd3);
    chk("t6_from", 64'(from_logic), 64'd0);
    rng_ack = 1'b1;
    rng_data = 6'd0;
    @(negedge clka);
    rng_ack = 1'b0;
    repeat (3) @(negedge clka);
    chk("t6_late_ack_row0", 64'(led_array[0]), 64'h00);
    chk("t6_late_ack_row5", 64'(led_array[5]), 64'h20);
    latency_tick("t6", RIGHT);
    chk("t6_move_row3", 64'(led_array[3]), 64'h0E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
